// File: rtl/regfile_arb_pkg.sv
// Shared state type and default constants for regfile_write_arbiter and its arbiter.
package regfile_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } arb_state_e;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int REG_ZERO       = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches upward from rr_ptr_i, wrapping at NUM_REQ.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    int cand;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(rr_ptr_i) + off) % NUM_REQ;
            if (!grant_valid_o && req_valid_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ requesters.
// Define REGFILE_ARB_INIT_EN to add the post-reset zero sweep and the busy flag.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_sel,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          write,
    output logic [ADDR_WIDTH-1:0]         write_sel,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] grant_sel;
    logic [DATA_WIDTH-1:0] grant_data;

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] write_sel_q, write_sel_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    arb_state_e            state_q;

`ifdef REGFILE_ARB_INIT_EN
    arb_state_e            state_d;
    logic [ADDR_WIDTH:0]   init_idx_q, init_idx_d;
    logic                  busy_q, busy_d;
`else
    assign state_q = ARB;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_valid_i   (req_valid),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign grant_sel  = req_sel[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign grant_data = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // The sweep index carries one extra bit so the last sweep write still sits in
    // INIT; grants open only once busy has dropped.
    always_comb begin
        req_ready    = '0;
        write_d      = 1'b0;
        write_sel_d  = write_sel_q;
        write_data_d = write_data_q;
        rr_ptr_d     = rr_ptr_q;
`ifdef REGFILE_ARB_INIT_EN
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        busy_d       = 1'b0;
`endif
        case (state_q)
`ifdef REGFILE_ARB_INIT_EN
            INIT: begin
                if (!init_idx_q[ADDR_WIDTH]) begin
                    write_d      = 1'b1;
                    write_sel_d  = init_idx_q[ADDR_WIDTH-1:0];
                    write_data_d = '0;
                    busy_d       = 1'b1;
                    init_idx_d   = init_idx_q + (ADDR_WIDTH+1)'(1);
                end else begin
                    state_d = ARB;
                end
            end
`endif
            default: begin
                req_ready = grant;
                if (grant_valid) begin
                    rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
                    if (grant_sel != ADDR_WIDTH'(REG_ZERO)) begin
                        write_d      = 1'b1;
                        write_sel_d  = grant_sel;
                        write_data_d = grant_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_q      <= 1'b0;
            write_sel_q  <= '0;
            write_data_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            write_q      <= write_d;
            write_sel_q  <= write_sel_d;
            write_data_q <= write_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

`ifdef REGFILE_ARB_INIT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            busy_q     <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    assign write      = write_q;
    assign write_sel  = write_sel_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes, a monitor checks them.
// Builds with or without REGFILE_ARB_INIT_EN.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DW      = 32;
    localparam int AW      = 5;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_sel;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write;
    logic [AW-1:0]         write_sel;
    logic [DW-1:0]         write_data;
    logic                  busy;

    typedef struct {
        logic [AW-1:0] sel;
        logic [DW-1:0] data;
        logic          busy;
        int            cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t front;
    int   checks   = 0;
    int   errors   = 0;
    int   cycleCnt = 0;

    regfile_write_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .write      (write),
        .write_sel  (write_sel),
        .write_data (write_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt++;

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of requests, checks the combinational grant, queues the expected write.
    task automatic applyStimulus(input string name, input logic [2:0] v,
                                 input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic [2:0] expReady, input logic expWrite,
                                 input logic [AW-1:0] expSel, input logic [DW-1:0] expData);
        exp_t e;
        req_valid = v;
        req_sel   = {s2, s1, s0};
        req_data  = {d2, d1, d0};
        #1;
        checkOutput({name, "_ready"}, DW'(req_ready), DW'(expReady));
        if (expWrite) begin
            e.sel  = expSel;
            e.data = expData;
            e.busy = 1'b0;
            e.cyc  = cycleCnt + 1;
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic pushSweep();
        exp_t e;
        expQ.delete();
        for (int i = 0; i < 32; i++) begin
            e.sel  = AW'(i);
            e.data = '0;
            e.busy = 1'b1;
            e.cyc  = cycleCnt + 1 + i;
            expQ.push_back(e);
        end
    endtask

    // Monitor: every write must match the head of the queue in content and cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (write) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_write actual write=1 sel=%0d data=%0h required write=0",
                                 write_sel, write_data);
                    end else begin
                        front = expQ.pop_front();
                        if (write_sel !== front.sel || write_data !== front.data ||
                            busy !== front.busy || cycleCnt != front.cyc) begin
                            errors++;
                            $display("[TB] FAIL write_beat actual sel=%0d data=%0h busy=%0b cyc=%0d required sel=%0d data=%0h busy=%0b cyc=%0d",
                                     write_sel, write_data, busy, cycleCnt,
                                     front.sel, front.data, front.busy, front.cyc);
                        end
                    end
                end else begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL idle_busy actual=%0b required=0", busy);
                    end
                    if (expQ.size() > 0 && expQ[0].cyc <= cycleCnt) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL missing_write actual write=0 required write=1 sel=%0d data=%0h cyc=%0d",
                                 expQ[0].sel, expQ[0].data, expQ[0].cyc);
                        front = expQ.pop_front();
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid = '0;
        req_sel   = '0;
        req_data  = '0;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_write",      DW'(write),      '0);
        checkOutput("reset_write_sel",  DW'(write_sel),  '0);
        checkOutput("reset_write_data", write_data,      '0);
        checkOutput("reset_busy",       DW'(busy),       '0);
        checkOutput("reset_req_ready",  DW'(req_ready),  '0);

`ifdef REGFILE_ARB_INIT_EN
        $display("[TB] sweep then reset when write_sel reaches 10");
        reset = 1'b0;
        pushSweep();
        for (int i = 0; i < 11; i++)
            applyStimulus("sweep_a", 3'b111, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 0, 0);
        checkOutput("mid_sweep_sel", DW'(write_sel), 32'd10);
        reset     = 1'b1;
        req_valid = '0;
        expQ.delete();
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        pushSweep();
        for (int i = 0; i < 33; i++)
            applyStimulus("sweep_b", 3'b111, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 0, 0);
`else
        reset = 1'b0;
`endif

        $display("[TB] round robin with all requesters valid");
        applyStimulus("rr0", 3'b111, 1, 2, 3, 'h10, 'h11, 'h12, 3'b001, 1'b1, 1, 'h10);
        applyStimulus("rr1", 3'b111, 4, 2, 3, 'h20, 'h11, 'h12, 3'b010, 1'b1, 2, 'h11);
        applyStimulus("rr2", 3'b111, 4, 5, 3, 'h20, 'h21, 'h12, 3'b100, 1'b1, 3, 'h12);
        applyStimulus("rr3", 3'b111, 4, 5, 6, 'h20, 'h21, 'h22, 3'b001, 1'b1, 4, 'h20);
        applyStimulus("rr4", 3'b111, 7, 5, 6, 'h30, 'h21, 'h22, 3'b010, 1'b1, 5, 'h21);
        applyStimulus("rr5", 3'b111, 7, 8, 6, 'h30, 'h31, 'h22, 3'b100, 1'b1, 6, 'h22);

        $display("[TB] single request and register zero");
        applyStimulus("single1", 3'b010, 0, 3, 0, 0, 'h5, 0, 3'b010, 1'b1, 3, 'h5);
        applyStimulus("reg0",    3'b001, 0, 0, 0, 'h7, 0, 0, 3'b001, 1'b0, 0, 0);
        checkOutput("reg0_no_write", DW'(write),     '0);
        checkOutput("hold_sel",      DW'(write_sel), 32'd3);
        checkOutput("hold_data",     write_data,     32'h5);
        applyStimulus("single2", 3'b100, 0, 0, 9, 0, 0, 'h99, 3'b100, 1'b1, 9, 'h99);

        $display("[TB] held request from requester 2");
        applyStimulus("held0", 3'b111, 10, 11, 12, 'hA0, 'hB1, 'hC2, 3'b001, 1'b1, 10, 'hA0);
        applyStimulus("held1", 3'b111, 13, 11, 12, 'hA3, 'hB1, 'hC2, 3'b010, 1'b1, 11, 'hB1);
        applyStimulus("held2", 3'b101, 13, 0,  12, 'hA3, 0,     'hC2, 3'b100, 1'b1, 12, 'hC2);
        applyStimulus("held3", 3'b001, 13, 0,  0,  'hA3, 0,     0,     3'b001, 1'b1, 13, 'hA3);

        $display("[TB] pointer holds across idle cycles");
        repeat (3) applyStimulus("idle", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 0, 0);
        applyStimulus("ptr_keep", 3'b101, 14, 0, 15, 'hE0, 0, 'hF2, 3'b100, 1'b1, 15, 'hF2);
        repeat (3) applyStimulus("drain", 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 0, 0);

        checkOutput("queue_drained", DW'(expQ.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
